// File: rtl/register_file.sv
// Architectural register file with rename tags: 32 committed values, each with a busy bit and producer ROB tag.
// Reads are combinational with a same-cycle commit bypass; commits/renames land at the next edge; rdy_in low stalls all but reset and flush.
module register_file #(
    parameter int REG_COUNT       = 32,
    parameter int ROB_INDEX_WIDTH = 4,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       clr_in,
    input  logic                       rob_to_reg_commit,
    input  logic [4:0]                 rob_to_reg_index,
    input  logic [ROB_INDEX_WIDTH-1:0] rob_to_reg_rob_index,
    input  logic [DATA_WIDTH-1:0]      rob_to_reg_val,
    input  logic                       dc_rename_en,
    input  logic [4:0]                 dc_rename_rd,
    input  logic [ROB_INDEX_WIDTH-1:0] dc_rename_index,
    input  logic [4:0]                 dc_rs1,
    input  logic [4:0]                 dc_rs2,
    output logic                       reg_rs1_busy,
    output logic [ROB_INDEX_WIDTH-1:0] reg_rs1_tag,
    output logic [DATA_WIDTH-1:0]      reg_rs1_val,
    output logic                       reg_rs2_busy,
    output logic [ROB_INDEX_WIDTH-1:0] reg_rs2_tag,
    output logic [DATA_WIDTH-1:0]      reg_rs2_val
);

    logic [DATA_WIDTH-1:0]      r_val  [REG_COUNT];
    logic                       r_busy [REG_COUNT];
    logic [ROB_INDEX_WIDTH-1:0] r_tag  [REG_COUNT];

    logic w_commit;
    logic w_rename;
    logic w_rs1_byp;
    logic w_rs2_byp;

    assign w_commit = rdy_in && rob_to_reg_commit && (rob_to_reg_index != 5'd0);
    assign w_rename = rdy_in && !clr_in && dc_rename_en && (dc_rename_rd != 5'd0);

    // Later assignments take priority: rename beats commit's clear, flush beats both.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_val[i]  <= '0;
                r_busy[i] <= 1'b0;
                r_tag[i]  <= '0;
            end
        end else begin
            if (w_commit) begin
                r_val[rob_to_reg_index] <= rob_to_reg_val;
                if (r_tag[rob_to_reg_index] == rob_to_reg_rob_index) begin
                    r_busy[rob_to_reg_index] <= 1'b0;
                    r_tag[rob_to_reg_index]  <= '0;
                end
            end
            if (w_rename) begin
                r_busy[dc_rename_rd] <= 1'b1;
                r_tag[dc_rename_rd]  <= dc_rename_index;
            end
            if (clr_in) begin
                for (int i = 0; i < REG_COUNT; i++) begin
                    r_busy[i] <= 1'b0;
                    r_tag[i]  <= '0;
                end
            end
        end
    end

    // Bypass ignores rdy_in: the committing value is forwarded even while stalled.
    assign w_rs1_byp = rob_to_reg_commit && (rob_to_reg_index == dc_rs1) && (dc_rs1 != 5'd0)
                       && (r_tag[dc_rs1] == rob_to_reg_rob_index);
    assign w_rs2_byp = rob_to_reg_commit && (rob_to_reg_index == dc_rs2) && (dc_rs2 != 5'd0)
                       && (r_tag[dc_rs2] == rob_to_reg_rob_index);

    always_comb begin
        reg_rs1_busy = 1'b0;
        reg_rs1_tag  = '0;
        reg_rs1_val  = '0;
        if (dc_rs1 != 5'd0) begin
            if (w_rs1_byp) begin
                reg_rs1_val = rob_to_reg_val;
            end else begin
                reg_rs1_busy = r_busy[dc_rs1];
                reg_rs1_tag  = r_busy[dc_rs1] ? r_tag[dc_rs1] : '0;
                reg_rs1_val  = r_val[dc_rs1];
            end
        end
    end

    always_comb begin
        reg_rs2_busy = 1'b0;
        reg_rs2_tag  = '0;
        reg_rs2_val  = '0;
        if (dc_rs2 != 5'd0) begin
            if (w_rs2_byp) begin
                reg_rs2_val = rob_to_reg_val;
            end else begin
                reg_rs2_busy = r_busy[dc_rs2];
                reg_rs2_tag  = r_busy[dc_rs2] ? r_tag[dc_rs2] : '0;
                reg_rs2_val  = r_val[dc_rs2];
            end
        end
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file with rename tags. Sits directly downstream of the reorder buffer's commit port.
- Holds 32 committed register values. Each register carries a busy bit and the ROB index of its latest in-flight producer.
- The decoder reads operand values or tags combinationally, and renames rd at issue.
- The ROB retires results into it and flushes all rename state on a misprediction.

Parameters:
- REG_COUNT, 32, number of architectural registers; x0 is hardwired to zero.
- ROB_INDEX_WIDTH, 4, width of a ROB index. Index 0 is the null tag and is never a valid producer.
- DATA_WIDTH, 32, register value width.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous, active-low reset.
- rdy_in  input  1  global ready; when low, state holds (except reset and flush).
- clr_in  input  1  misprediction flush from the ROB.
- rob_to_reg_commit  input  1  commit strobe.
- rob_to_reg_index  input  5  destination register of the committing entry.
- rob_to_reg_rob_index  input  ROB_INDEX_WIDTH  ROB index of the committing entry.
- rob_to_reg_val  input  DATA_WIDTH  committed value.
- dc_rename_en  input  1  decoder issues an instruction that writes rd.
- dc_rename_rd  input  5  rd being renamed.
- dc_rename_index  input  ROB_INDEX_WIDTH  ROB index allocated to it.
- dc_rs1  input  5  source register 1.
- dc_rs2  input  5  source register 2.
- reg_rs1_busy  output  1  rs1 awaits an in-flight producer.
- reg_rs1_tag  output  ROB_INDEX_WIDTH  producer ROB index for rs1 (0 if not busy).
- reg_rs1_val  output  DATA_WIDTH  committed rs1 value.
- reg_rs2_busy, reg_rs2_tag, reg_rs2_val  outputs  1/ROB_INDEX_WIDTH/DATA_WIDTH  same as rs1, for rs2.

Behaviour:
- Reset: when rst_in is low at a clock edge, all values, busy bits and tags clear to 0. Read outputs then show busy=0, tag=0, val=0. Reset overrides every other input.
- Read ports: combinational from current state, with a same-cycle commit bypass.
  - Bypass condition: rob_to_reg_commit=1, rob_to_reg_index==rs, rs!=0, and tag[rs]==rob_to_reg_rob_index.
  - Under the bypass, outputs are busy=0, tag=0, val=rob_to_reg_val.
  - Rename bypass: none. A rename in the current cycle is seen by reads in the next cycle; the decoder handles intra-cycle dependence.
  - rs=0 always returns busy=0, tag=0, val=0.
  - Whenever busy=0, tag reads as 0.
- Commit (rdy_in=1, rob_to_reg_commit=1, rob_to_reg_index!=0):
  - val[rd] <= rob_to_reg_val, regardless of tag.
  - busy[rd] and tag[rd] clear only if tag[rd]==rob_to_reg_rob_index. Otherwise a younger producer still owns the register and they stay.
- Rename (rdy_in=1, clr_in=0, dc_rename_en=1, dc_rename_rd!=0): busy[rd] <= 1 and tag[rd] <= dc_rename_index. The value is untouched.
- Commit and rename to the same rd in one cycle: the value is written and rename wins (busy=1, tag=new index), even if the commit tag matched.
- Flush (clr_in=1): applied regardless of rdy_in.
  - All busy bits and tags clear; values are kept.
  - A commit strobe in the same cycle still writes its value, then the flush clear applies.
  - A rename in the flush cycle is dropped.
- rdy_in=0 with clr_in=0: no commit or rename takes effect. Reads continue, including the bypass.
- Writes to x0 by commit or rename are ignored.
- Latency: a commit or rename is visible in state at the next edge; the commit bypass gives zero-cycle visibility.
- Single write per register per cycle; there are no other simultaneity cases.

Test Plan:
- Reset: hold rst_in=0 for 2 cycles with random commit and rename inputs, release -> every rs1/rs2 read returns busy=0, tag=0, val=0.
- Rename then commit:
  - Rename x5 to tag 3; the next cycle reads busy=1, tag=3.
  - Commit x5 with rob index 3, val 0xDEADBEEF -> same-cycle read shows busy=0, val=0xDEADBEEF; the following cycle the state matches.
- Stale commit: rename x7 to tag 2, then to tag 6; commit x7 with index 2, val 0x11 -> val=0x11, busy=1, tag=6 remain. Commit with index 6, val 0x22 -> busy=0, val=0x22.
- Same-cycle commit and rename: x9 has tag 4; commit x9 index 4, val 0x55 while renaming x9 to tag 8 -> next cycle val=0x55, busy=1, tag=8.
- Flush: rename x1, x2 and x3 to tags 1, 2, 3; assert clr_in together with commit x1 index 1, val 0x99 and rename x4 to tag 5 -> all busy=0 and all tags 0; x1=0x99; x4 not busy, value unchanged.
- x0 and rdy_in:
  - Rename and commit x0 with val 0x1234 -> x0 reads busy=0, val=0.
  - With rdy_in=0, a commit to x10 has no effect; a flush with rdy_in=0 still clears busy bits.
